// File: rtl/cr_rst_seq_pkg.sv
// rtl/cr_rst_seq_pkg.sv - shared types and helpers for the reset release sequencer
package cr_rst_seq_pkg;

  typedef enum logic [1:0] {
    DELAY    = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } state_t;

  // Stage index width; a single-stage build still needs a 1-bit index.
  function automatic int idx_width(input int n_stages);
    return (n_stages <= 1) ? 1 : $clog2(n_stages);
  endfunction

endpackage

// File: rtl/cr_rst_seq.sv
// rtl/cr_rst_seq.sv - reset release sequencer; optional ack timeout via CR_RST_SEQ_TIMEOUT_EN
module cr_rst_seq
  import cr_rst_seq_pkg::*;
#(
  parameter int N_STAGES    = 4,
  parameter int STAGE_DLY   = 16,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                soft_rst_req,
  input  logic [N_STAGES-1:0] stage_ack,
  output logic [N_STAGES-1:0] stage_rst_n,
  output logic                seq_done,
  output logic                busy,
  output logic                timeout_err
);

  localparam int IDX_W = idx_width(N_STAGES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DLY - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  logic ack_hit;
  logic tmo_hit;

  // Only the acknowledge of the stage currently being waited on matters.
  assign ack_hit = stage_ack[idx];

`ifdef CR_RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
  // A stuck ack is treated as arrived once the wait budget runs out.
  assign tmo_hit = (cnt == TMO_LAST);
`else
  logic unused_tmo;
  assign unused_tmo = ACK_TIMEOUT[0];
  assign tmo_hit    = 1'b0;
`endif

  // Sequencer FSM with counter and registered outputs; soft request beats ack and count terminal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= DELAY;
      idx         <= '0;
      cnt         <= '0;
      stage_rst_n <= '0;
      seq_done    <= 1'b0;
      busy        <= 1'b1;
      timeout_err <= 1'b0;
    end else if (soft_rst_req) begin
      state       <= DELAY;
      idx         <= '0;
      cnt         <= '0;
      stage_rst_n <= '0;
      seq_done    <= 1'b0;
      busy        <= 1'b1;
    end else begin
      case (state)
        DELAY: begin
          if (cnt == DLY_LAST) begin
            stage_rst_n[idx] <= 1'b1;
            cnt              <= '0;
            state            <= WAIT_ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack_hit || tmo_hit) begin
            if (!ack_hit) begin
              timeout_err <= 1'b1;
            end
            cnt <= '0;
            if (idx == LAST_IDX) begin
              state    <= DONE;
              seq_done <= 1'b1;
              busy     <= 1'b0;
            end else begin
              idx   <= idx + 1'b1;
              state <= DELAY;
            end
          end else begin
`ifdef CR_RST_SEQ_TIMEOUT_EN
            cnt <= cnt + 1'b1;
`else
            cnt <= cnt;
`endif
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= DELAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cr_rst_seq.sv
// tb/tb_cr_rst_seq.sv - scoreboard bench for the reset release sequencer
module tb_cr_rst_seq;

  localparam int N  = 4;
  localparam int D  = 16;

  typedef struct packed {
    logic [4:0] val;
    int         edge_n;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         soft_rst_req;
  logic [N-1:0] stage_ack;
  logic [N-1:0] stage_rst_n;
  logic         seq_done;
  logic         busy;
  logic         timeout_err;

  int   checks;
  int   errors;
  int   edge_cnt;
  logic mon_en;
  logic [4:0] last_obs;
  exp_t sb[$];

  cr_rst_seq #(
    .N_STAGES(N),
    .STAGE_DLY(D),
    .CNT_W(8),
    .ACK_TIMEOUT(200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .soft_rst_req(soft_rst_req),
    .stage_ack(stage_ack),
    .stage_rst_n(stage_rst_n),
    .seq_done(seq_done),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: each change of {stage_rst_n, seq_done} pops one scoreboard entry.
  always @(negedge clk) begin
    if (mon_en && ({stage_rst_n, seq_done} != last_obs)) begin
      if (sb.size() == 0) begin
        check("unexpected_change", {27'd0, stage_rst_n, seq_done}, {27'd0, last_obs});
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_val", {27'd0, stage_rst_n, seq_done}, {27'd0, e.val});
        check("out_edge", edge_cnt, e.edge_n);
      end
    end
    last_obs <= {stage_rst_n, seq_done};
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input logic [3:0] rn, input logic done, input int e);
    exp_t x;
    x.val    = {rn, done};
    x.edge_n = e;
    sb.push_back(x);
  endtask

  // Full sequence with acks high, counted from the edge before the first counting edge.
  task automatic push_seq(input int base);
    expect_ev(4'b0001, 1'b0, base + 16);
    expect_ev(4'b0011, 1'b0, base + 33);
    expect_ev(4'b0111, 1'b0, base + 50);
    expect_ev(4'b1111, 1'b0, base + 67);
    expect_ev(4'b1111, 1'b1, base + 68);
  endtask

  task automatic drain(input string tag, input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    tick(1);
    check(tag, sb.size(), 0);
  endtask

  initial begin
    int base;
    int r;
    checks       = 0;
    errors       = 0;
    edge_cnt     = 0;
    mon_en       = 1'b0;
    rst          = 1'b1;
    soft_rst_req = 1'b0;
    stage_ack    = 4'b1111;
    tick(3);

    check("rst_stage_rst_n", stage_rst_n, 0);
    check("rst_seq_done", seq_done, 0);
    check("rst_busy", busy, 1);
    check("rst_timeout_err", timeout_err, 0);

    // Power-up sequence, acks tied high.
    rst  = 1'b0;
    base = edge_cnt;
    push_seq(base);
    mon_en = 1'b1;
    drain("seq1_drain", 200);
    check("seq1_busy", busy, 0);
    check("seq1_done", seq_done, 1);

    // Soft re-sequence from DONE with a slow stage 1 ack and an early stage 2 ack.
    stage_ack    = 4'b0101;
    soft_rst_req = 1'b1;
    base = edge_cnt;
    expect_ev(4'b0000, 1'b0, base + 1);
    expect_ev(4'b0001, 1'b0, base + 17);
    expect_ev(4'b0011, 1'b0, base + 34);
    tick(1);
    soft_rst_req = 1'b0;
    check("soft_busy", busy, 1);
    check("soft_done", seq_done, 0);
    check("soft_rst_n", stage_rst_n, 0);
    r = base + 34;
    drain("slow_ack_drain1", 100);
    while (edge_cnt < r + 40) tick(1);
    check("slow_ack_busy", busy, 1);
    check("slow_ack_hold", stage_rst_n, 4'b0011);
    stage_ack = 4'b1111;
    expect_ev(4'b0111, 1'b0, r + 57);
    expect_ev(4'b1111, 1'b0, r + 74);
    expect_ev(4'b1111, 1'b1, r + 75);
    drain("slow_ack_drain2", 100);

    // Asynchronous reset in the middle of stage 2's delay.
    soft_rst_req = 1'b1;
    base = edge_cnt;
    expect_ev(4'b0000, 1'b0, base + 1);
    expect_ev(4'b0001, 1'b0, base + 17);
    expect_ev(4'b0011, 1'b0, base + 34);
    tick(1);
    soft_rst_req = 1'b0;
    drain("pre_rst_drain", 100);
    tick(5);
    check("pre_rst_rst_n", stage_rst_n, 4'b0011);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_rst_n", stage_rst_n, 0);
    check("async_rst_busy", busy, 1);
    tick(2);
    rst  = 1'b0;
    base = edge_cnt;
    push_seq(base);
    mon_en = 1'b1;
    drain("post_rst_drain", 200);

    // Soft request coincides with the ack of stage 0: soft must win.
    stage_ack    = 4'b0000;
    soft_rst_req = 1'b1;
    base = edge_cnt;
    expect_ev(4'b0000, 1'b0, base + 1);
    expect_ev(4'b0001, 1'b0, base + 17);
    tick(1);
    soft_rst_req = 1'b0;
    drain("coinc_drain1", 100);
    tick(3);
    stage_ack    = 4'b1111;
    soft_rst_req = 1'b1;
    base = edge_cnt;
    expect_ev(4'b0000, 1'b0, base + 1);
    expect_ev(4'b0001, 1'b0, base + 17);
    tick(1);
    stage_ack    = 4'b0000;
    soft_rst_req = 1'b0;
    check("coinc_rst_n", stage_rst_n, 0);
    check("coinc_busy", busy, 1);
    r = base + 17;
`ifdef CR_RST_SEQ_TIMEOUT_EN
    expect_ev(4'b0011, 1'b0, r + 216);
    while (edge_cnt < r + 199) tick(1);
    check("tmo_before", timeout_err, 0);
    tick(1);
    check("tmo_set", timeout_err, 1);
    drain("tmo_drain", 100);
    soft_rst_req = 1'b1;
    base = edge_cnt;
    expect_ev(4'b0000, 1'b0, base + 1);
    tick(1);
    soft_rst_req = 1'b0;
    check("tmo_sticky", timeout_err, 1);
    drain("tmo_soft_drain", 20);
`else
    drain("coinc_drain2", 100);
    while (edge_cnt < r + 250) tick(1);
    check("stuck_timeout_err", timeout_err, 0);
    check("stuck_rst_n", stage_rst_n, 4'b0001);
    check("stuck_busy", busy, 1);
`endif
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
